avl_bus_ram_slave: RTL and testbench
====================================

Name: avl_bus_ram_slave

Overview:
- Synthesizable word-addressed on-chip RAM slave on the avl_bus; sits directly downstream of the bus master and interconnect, executing their read/write commands.
- Serves single and burst transfers and buffers read responses in an in-order FIFO, so the master's random `resp_ready` backpressure never loses data.
- Checks burst-beat sequencing and flags protocol violations, giving the master bench a real endpoint whose returned data it can verify.

Parameters:
- MEM_AW, 10: log2 of memory depth in 32-bit words (1024 words).
- RESP_FIFO_DEPTH, 4: read-response FIFO entries; power of two, minimum 2.
- BURST_CW, 8: width of `burst_count`; must cover ALV_BURST_MAX_COUNT-1.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rest  in  1  asynchronous, active-high reset.
- address  in  32  byte address; word index = address[MEM_AW+1:2]; upper bits and [1:0] ignored.
- byte_en  in  4  write byte lanes; ignored for reads.
- read  in  1  read command valid.
- write  in  1  write command valid; read and write together count as a read.
- write_data  in  32  write data.
- begin_burst_transfer  in  1  first beat of a burst.
- burst_count  in  BURST_CW  beats remaining after this one; 0 on single transfers and on the last beat.
- request_ready  out  1  command accepted this cycle when high.
- read_data  out  32  FIFO head data.
- read_data_valid  out  1  FIFO non-empty.
- resp_ready  in  1  master accepts the response this cycle.
- burst_err  out  1  sticky burst-protocol error flag.

Behaviour:
- Accept: when (read|write) && request_ready at a rising edge.
- Write: on accept, each byte lane i with byte_en[i]=1 updates mem[idx][8i+7:8i]; other lanes are unchanged.
- Read pipeline: on accept, mem[idx] is latched into a stage register with pipe_valid=1. The next edge pushes it into the FIFO, so minimum latency from accept to read_data_valid is 2 cycles.
- Read returns the full 32-bit word.
- Ordering: one command per cycle. A read accepted the cycle after a write to the same word returns the written data. Responses come back in acceptance order.
- Credit: outstanding = pipe_valid + fifo_count.
  - request_ready = (outstanding < RESP_FIFO_DEPTH), driven from registers only, with no combinational path from resp_ready.
  - Writes are also gated by request_ready.
- Pop: when read_data_valid && resp_ready, the head advances.
  - Push and pop in the same cycle keep the count unchanged.
  - The FIFO never overflows, by credit.
  - Pointers wrap modulo RESP_FIFO_DEPTH.
- Burst FSM, state IDLE:
  - An accepted beat with begin_burst_transfer=1 and burst_count!=0 moves to BURST.
  - On entry it latches exp_addr=address+4, rem=burst_count and the command type.
  - begin_burst_transfer with burst_count=0 is treated as a single transfer.
- Burst FSM, state BURST (checks apply to accepted beats only; idle cycles are allowed):
  - A beat is a violation if any of these hold: begin_burst_transfer=1; address!=exp_addr; burst_count!=rem-1; the type differs from the latched type.
  - A violation sets burst_err=1 (sticky until reset). The beat still executes.
  - Then exp_addr+=4 and rem=burst_count.
  - When burst_count==0 the FSM returns to IDLE.
- Wrap: an index that passes the top of memory wraps to word 0 (natural truncation).
- Reset (async, any time, including mid-burst or with a non-empty FIFO):
  - FIFO and pipe flushed; FSM to IDLE.
  - read_data_valid=0, read_data=0, burst_err=0, request_ready=1 once reset deasserts.
  - RAM contents are not cleared.

Test Plan:
- Write 0xDEADBEEF to 0x40 with byte_en=1111, then read 0x40 with resp_ready=1: read_data_valid rises 2 cycles after accept with 0xDEADBEEF.
- Preload 0x11223344 at 0x8; write 0xAABBCCDD with byte_en=0011; read: returns 0x1122CCDD.
- Issue 6 back-to-back reads with resp_ready=0: request_ready falls after the 4th accept, and no further accepts occur. Release resp_ready: 4 responses arrive in order, then the remaining 2 reads are accepted and returned.
- Legal read burst: address 0x100, burst_count=3, then beats 0x104/2, 0x108/1, 0x10C/0 with idle gaps in between: 4 correct responses, burst_err=0, FSM returns to IDLE.
- Illegal burst: second beat at 0x108 instead of 0x104: burst_err=1 and stays high; the beat still executes.
- Assert rest with 3 responses queued and mid-burst: read_data_valid=0 immediately, request_ready=1 after release, and a subsequent read returns pre-reset RAM data.

Source files
------------

// File: rtl/avl_bus_ram_slave.sv
// Word-addressed on-chip RAM slave for the avl_bus: byte-lane writes, pipelined reads
// into an in-order response FIFO with credit-based request_ready, and burst sequencing checks.
module avl_bus_ram_slave #(
  parameter int unsigned MEM_AW          = 10,
  parameter int unsigned RESP_FIFO_DEPTH = 4,
  parameter int unsigned BURST_CW        = 8
) (
  input  logic                clk,
  input  logic                rest,
  input  logic [31:0]         address,
  input  logic [3:0]          byte_en,
  input  logic                read,
  input  logic                write,
  input  logic [31:0]         write_data,
  input  logic                begin_burst_transfer,
  input  logic [BURST_CW-1:0] burst_count,
  output logic                request_ready,
  output logic [31:0]         read_data,
  output logic                read_data_valid,
  input  logic                resp_ready,
  output logic                burst_err
);

  localparam int unsigned MEM_DEPTH = 1 << MEM_AW;
  localparam int unsigned PW        = $clog2(RESP_FIFO_DEPTH);
  localparam int unsigned CW        = PW + 1;

  typedef enum logic {S_IDLE, S_BURST} state_e;

  logic [31:0]         mem [MEM_DEPTH];
  logic [31:0]         fifo_q [RESP_FIFO_DEPTH];
  logic [31:0]         pipe_data_q;
  logic                pipe_valid_q;
  logic [PW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]       count_q, count_d;
  logic                ready_q, ready_d;

  state_e              state_q, state_d;
  logic [31:0]         exp_addr_q, exp_addr_d;
  logic [BURST_CW-1:0] rem_q, rem_d;
  logic                type_q, type_d;
  logic                burst_err_q, burst_err_d;
  logic                viol_c;

  logic [MEM_AW-1:0]   idx_c;
  logic                accept_c, rd_acc_c, wr_acc_c;
  logic                push_c, pop_c;

  // Read wins when read and write are both asserted.
  assign idx_c    = address[MEM_AW+1:2];
  assign accept_c = (read | write) & ready_q;
  assign rd_acc_c = accept_c & read;
  assign wr_acc_c = accept_c & ~read;

  assign push_c   = pipe_valid_q;
  assign pop_c    = (count_q != '0) & resp_ready;
  assign count_d  = count_q + CW'(push_c) - CW'(pop_c);
  // Credit counts the in-flight pipe beat so the FIFO can never overflow.
  assign ready_d  = (CW'(rd_acc_c) + count_d) < CW'(RESP_FIFO_DEPTH);

  always_ff @(posedge clk) begin : mem_port
    if (wr_acc_c) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) mem[idx_c][8*i +: 8] <= write_data[8*i +: 8];
      end
    end
    if (rd_acc_c) pipe_data_q <= mem[idx_c];
  end

  always_ff @(posedge clk) begin : fifo_store
    if (push_c) fifo_q[wr_ptr_q] <= pipe_data_q;
  end

  always_ff @(posedge clk or posedge rest) begin : fifo_ctrl
    if (rest) begin
      pipe_valid_q <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      ready_q      <= 1'b1;
    end else begin
      pipe_valid_q <= rd_acc_c;
      if (push_c) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_c)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q      <= count_d;
      ready_q      <= ready_d;
    end
  end

  always_ff @(posedge clk or posedge rest) begin : fsm_state
    if (rest) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin : fsm_next
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept_c && begin_burst_transfer && (burst_count != '0)) state_d = S_BURST;
      S_BURST: if (accept_c && (burst_count == '0)) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin : fsm_out
    viol_c      = 1'b0;
    exp_addr_d  = exp_addr_q;
    rem_d       = rem_q;
    type_d      = type_q;
    case (state_q)
      S_IDLE: begin
        if (accept_c && begin_burst_transfer && (burst_count != '0)) begin
          exp_addr_d = address + 32'd4;
          rem_d      = burst_count;
          type_d     = read;
        end
      end
      S_BURST: begin
        if (accept_c) begin
          viol_c     = begin_burst_transfer
                     | (address != exp_addr_q)
                     | (burst_count != BURST_CW'(rem_q - BURST_CW'(1)))
                     | (read != type_q);
          exp_addr_d = exp_addr_q + 32'd4;
          rem_d      = burst_count;
        end
      end
      default: viol_c = 1'b0;
    endcase
    burst_err_d = burst_err_q | viol_c;
  end

  always_ff @(posedge clk or posedge rest) begin : burst_regs
    if (rest) begin
      exp_addr_q  <= '0;
      rem_q       <= '0;
      type_q      <= 1'b0;
      burst_err_q <= 1'b0;
    end else begin
      exp_addr_q  <= exp_addr_d;
      rem_q       <= rem_d;
      type_q      <= type_d;
      burst_err_q <= burst_err_d;
    end
  end

  assign request_ready   = ready_q;
  assign read_data_valid = (count_q != '0);
  assign read_data       = read_data_valid ? fifo_q[rd_ptr_q] : 32'd0;
  assign burst_err       = burst_err_q;

endmodule

// File: tb/tb_avl_bus_ram_slave.sv
// Scoreboard bench for avl_bus_ram_slave: a byte-lane memory model predicts every read
// response at accept time; responses are compared in order as they are popped.
module tb_avl_bus_ram_slave;

  logic        clk = 1'b0;
  logic        rest;
  logic [31:0] address;
  logic [3:0]  byte_en;
  logic        read, write;
  logic [31:0] write_data;
  logic        begin_burst_transfer;
  logic [7:0]  burst_count;
  logic        request_ready;
  logic [31:0] read_data;
  logic        read_data_valid;
  logic        resp_ready;
  logic        burst_err;

  avl_bus_ram_slave dut (
    .clk                  (clk),
    .rest                 (rest),
    .address              (address),
    .byte_en              (byte_en),
    .read                 (read),
    .write                (write),
    .write_data           (write_data),
    .begin_burst_transfer (begin_burst_transfer),
    .burst_count          (burst_count),
    .request_ready        (request_ready),
    .read_data            (read_data),
    .read_data_valid      (read_data_valid),
    .resp_ready           (resp_ready),
    .burst_err            (burst_err)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          acc_cnt  = 0;
  logic [31:0] model [0:1023];
  logic [31:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Inputs are stable from posedge+1, so the negedge sees what the next edge will sample.
  always @(negedge clk) begin
    if (rest) begin
      exp_q.delete();
    end else begin
      if (read_data_valid && resp_ready) begin
        if (exp_q.size() == 0) check("unexpected_resp", read_data, 32'hxxxxxxxx);
        else check("rdata", read_data, exp_q.pop_front());
      end
      if ((read || write) && request_ready) begin
        acc_cnt++;
        if (read) begin
          exp_q.push_back(model[address[11:2]]);
        end else begin
          for (int i = 0; i < 4; i++)
            if (byte_en[i]) model[address[11:2]][8*i +: 8] = write_data[8*i +: 8];
        end
      end
    end
  end

  task automatic do_cmd(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [3:0] be, input logic [31:0] d,
                        input logic bb, input logic [7:0] bc);
    int   n   = 0;
    logic acc = 1'b0;
    read = rd; write = wr; address = a; byte_en = be; write_data = d;
    begin_burst_transfer = bb; burst_count = bc;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = request_ready;
      @(posedge clk); #1;
      n++;
    end
    read = 1'b0; write = 1'b0; begin_burst_transfer = 1'b0; burst_count = 8'd0;
    if (!acc) check("accept_timeout", 32'(acc), 32'd1);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wr_word(input logic [31:0] a, input logic [31:0] d);
    do_cmd(1'b0, 1'b1, a, 4'hF, d, 1'b0, 8'd0);
  endtask

  task automatic rd_word(input logic [31:0] a);
    do_cmd(1'b1, 1'b0, a, 4'h0, 32'd0, 1'b0, 8'd0);
  endtask

  logic [31:0] stall_addr [6];
  int          base;

  initial begin
    rest = 1'b1; address = '0; byte_en = '0; read = 1'b0; write = 1'b0;
    write_data = '0; begin_burst_transfer = 1'b0; burst_count = '0; resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rest = 1'b0;
    #1;
    check("rst_valid", 32'(read_data_valid), 32'd0);
    check("rst_rdata", read_data, 32'd0);
    check("rst_err", 32'(burst_err), 32'd0);
    check("rst_ready", 32'(request_ready), 32'd1);
    @(posedge clk); #1;

    // Full write then read with two-cycle latency.
    resp_ready = 1'b1;
    wr_word(32'h40, 32'hDEADBEEF);
    rd_word(32'h40);
    check("lat_pipe", 32'(read_data_valid), 32'd0);
    @(posedge clk); #1;
    check("lat_valid", 32'(read_data_valid), 32'd1);
    check("lat_data", read_data, 32'hDEADBEEF);
    drain();

    // Partial byte-lane write.
    wr_word(32'h8, 32'h11223344);
    do_cmd(1'b0, 1'b1, 32'h8, 4'b0011, 32'hAABBCCDD, 1'b0, 8'd0);
    rd_word(32'h8);
    @(posedge clk); #1;
    check("byte_en_data", read_data, 32'h1122CCDD);
    drain();

    for (int i = 0; i < 4; i++) wr_word(32'h100 + 32'(4*i), 32'h1000_0000 + 32'(i));
    for (int i = 0; i < 3; i++) wr_word(32'h200 + 32'(4*i), 32'h2000_0000 + 32'(i));

    // Backpressure: only four reads may be outstanding.
    stall_addr[0] = 32'h40;  stall_addr[1] = 32'h8;   stall_addr[2] = 32'h100;
    stall_addr[3] = 32'h104; stall_addr[4] = 32'h108; stall_addr[5] = 32'h10C;
    resp_ready = 1'b0;
    base = acc_cnt;
    fork
      for (int i = 0; i < 6; i++) rd_word(stall_addr[i]);
      begin
        repeat (10) @(posedge clk);
        #2;
        check("stall_accepts", 32'(acc_cnt - base), 32'd4);
        check("stall_ready", 32'(request_ready), 32'd0);
        check("stall_valid", 32'(read_data_valid), 32'd1);
        resp_ready = 1'b1;
      end
    join
    drain();
    check("stall_total", 32'(acc_cnt - base), 32'd6);

    // Legal read burst with idle gaps.
    do_cmd(1'b1, 1'b0, 32'h100, 4'h0, 32'd0, 1'b1, 8'd3);
    repeat (2) @(posedge clk);
    #1 do_cmd(1'b1, 1'b0, 32'h104, 4'h0, 32'd0, 1'b0, 8'd2);
    @(posedge clk);
    #1 do_cmd(1'b1, 1'b0, 32'h108, 4'h0, 32'd0, 1'b0, 8'd1);
    repeat (3) @(posedge clk);
    #1 do_cmd(1'b1, 1'b0, 32'h10C, 4'h0, 32'd0, 1'b0, 8'd0);
    drain();
    check("legal_err", 32'(burst_err), 32'd0);

    // Illegal burst: second beat skips an address.
    do_cmd(1'b1, 1'b0, 32'h200, 4'h0, 32'd0, 1'b1, 8'd2);
    check("idle_after_burst", 32'(burst_err), 32'd0);
    do_cmd(1'b1, 1'b0, 32'h208, 4'h0, 32'd0, 1'b0, 8'd1);
    check("illegal_err", 32'(burst_err), 32'd1);
    do_cmd(1'b1, 1'b0, 32'h20C, 4'h0, 32'd0, 1'b0, 8'd0);
    drain();
    repeat (3) @(posedge clk);
    #1 check("err_sticky", 32'(burst_err), 32'd1);

    // Reset mid-burst with three queued responses.
    resp_ready = 1'b0;
    do_cmd(1'b1, 1'b0, 32'h100, 4'h0, 32'd0, 1'b1, 8'd3);
    do_cmd(1'b1, 1'b0, 32'h104, 4'h0, 32'd0, 1'b0, 8'd2);
    do_cmd(1'b1, 1'b0, 32'h108, 4'h0, 32'd0, 1'b0, 8'd1);
    repeat (2) @(posedge clk);
    #1 check("pre_rst_valid", 32'(read_data_valid), 32'd1);
    rest = 1'b1;
    #1;
    check("rst_async_valid", 32'(read_data_valid), 32'd0);
    check("rst_async_rdata", read_data, 32'd0);
    repeat (2) @(posedge clk);
    #1 rest = 1'b0;
    #1;
    check("post_rst_ready", 32'(request_ready), 32'd1);
    check("post_rst_err", 32'(burst_err), 32'd0);
    check("post_rst_valid", 32'(read_data_valid), 32'd0);
    resp_ready = 1'b1;
    rd_word(32'h40);
    @(posedge clk); #1;
    check("ram_kept", read_data, 32'hDEADBEEF);
    drain();
    do_cmd(1'b1, 1'b0, 32'h200, 4'h0, 32'd0, 1'b1, 8'd1);
    do_cmd(1'b1, 1'b0, 32'h204, 4'h0, 32'd0, 1'b0, 8'd0);
    drain();
    check("post_rst_burst_err", 32'(burst_err), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
